// File: rtl/urv_muldiv_seq.sv
// Sequential RISC-V M-extension unit: shift-add multiplier and restoring divider, BITS_PER_CYCLE bits per step.
// Define URV_DIVIDE_EN to build the divider; without it, DIV/DIVU/REM/REMU complete at once with a zero result.
module urv_muldiv_seq #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             x_stall_i,
  input  logic             x_kill_i,
  input  logic             d_valid_i,
  input  logic             d_is_muldiv_i,
  input  logic [2:0]       d_fun_i,
  input  logic [WIDTH-1:0] d_rs1_i,
  input  logic [WIDTH-1:0] d_rs2_i,
  output logic             x_stall_req_o,
  output logic [WIDTH-1:0] x_rd_o,
  output logic             x_done_o
);

  localparam int BPC = BITS_PER_CYCLE;
  localparam int N   = WIDTH / BITS_PER_CYCLE;
  localparam int CW  = $clog2(N + 1);

  localparam logic [1:0]    S_IDLE    = 2'd0;
  localparam logic [1:0]    S_BUSY    = 2'd1;
  localparam logic [1:0]    S_DONE    = 2'd2;
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [1:0]       state_r;
  logic [2:0]       fun_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] rd_r;
  logic [CW-1:0]    cnt_r;
  logic             neg_r;

  logic             start_s;
  logic             fast_s;
  logic             rs1_neg_s;
  logic             rs2_neg_s;
  logic             neg_s;
  logic [WIDTH-1:0] mag1_s;
  logic [WIDTH-1:0] mag2_s;
  logic [WIDTH-1:0] fast_res_s;

  logic [WIDTH+BPC-1:0] hi_ext_s;
  logic [WIDTH-1:0]     mul_hi_s;
  logic [WIDTH-1:0]     mul_lo_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     step_hi_s;
  logic [WIDTH-1:0]     step_lo_s;
  logic [WIDTH-1:0]     final_s;

  assign start_s       = (state_r == S_IDLE) & d_valid_i & d_is_muldiv_i & ~x_kill_i;
  assign x_stall_req_o = start_s | (state_r == S_BUSY);
  assign x_done_o      = (state_r == S_DONE);
  assign x_rd_o        = rd_r;

  // Operands are reduced to magnitudes; the sign of the result is reapplied on the last step.
  always_comb begin
    rs1_neg_s = 1'b0;
    rs2_neg_s = 1'b0;
    case (d_fun_i)
      3'd1, 3'd4, 3'd6: begin
        rs1_neg_s = d_rs1_i[WIDTH-1];
        rs2_neg_s = d_rs2_i[WIDTH-1];
      end
      3'd2: begin
        rs1_neg_s = d_rs1_i[WIDTH-1];
        rs2_neg_s = 1'b0;
      end
      default: begin
        rs1_neg_s = 1'b0;
        rs2_neg_s = 1'b0;
      end
    endcase
    mag1_s = rs1_neg_s ? -d_rs1_i : d_rs1_i;
    mag2_s = rs2_neg_s ? -d_rs2_i : d_rs2_i;
    case (d_fun_i)
      3'd6:    neg_s = rs1_neg_s;
      default: neg_s = rs1_neg_s ^ rs2_neg_s;
    endcase
  end

`ifdef URV_DIVIDE_EN
  logic div0_s;
  logic ovf_s;

  // Divide by zero and signed overflow bypass the iteration entirely.
  always_comb begin
    div0_s = (d_rs2_i == {WIDTH{1'b0}});
    ovf_s  = ((d_fun_i == 3'd4) | (d_fun_i == 3'd6)) &
             (d_rs1_i == {1'b1, {(WIDTH-1){1'b0}}}) &
             (d_rs2_i == {WIDTH{1'b1}});
    fast_s = d_fun_i[2] & (div0_s | ovf_s);
    if (div0_s) begin
      fast_res_s = d_fun_i[1] ? d_rs1_i : {WIDTH{1'b1}};
    end else if (ovf_s) begin
      fast_res_s = d_fun_i[1] ? {WIDTH{1'b0}} : d_rs1_i;
    end else begin
      fast_res_s = {WIDTH{1'b0}};
    end
  end

  logic [WIDTH:0]   rt_s;
  logic [WIDTH-1:0] div_r_s;
  logic [WIDTH-1:0] div_q_s;

  // Restoring division: remainder in hi_r, dividend shifting out of lo_r as quotient shifts in.
  always_comb begin
    div_r_s = hi_r;
    div_q_s = lo_r;
    rt_s    = {(WIDTH+1){1'b0}};
    for (int i = 0; i < BPC; i++) begin
      rt_s    = {div_r_s, div_q_s[WIDTH-1]};
      div_q_s = {div_q_s[WIDTH-2:0], 1'b0};
      if (rt_s >= {1'b0, a_r}) begin
        rt_s       = rt_s - {1'b0, a_r};
        div_q_s[0] = 1'b1;
      end else begin
        rt_s = rt_s;
      end
      div_r_s = rt_s[WIDTH-1:0];
    end
  end
`else
  // Without a divider every divide op completes immediately with zero.
  always_comb begin
    fast_s     = d_fun_i[2];
    fast_res_s = {WIDTH{1'b0}};
  end
`endif

  // Shift-add multiply step: {hi_r, lo_r} shifts right as multiplier bits are consumed from lo_r.
  always_comb begin
    hi_ext_s = {{BPC{1'b0}}, hi_r};
    for (int i = 0; i < BPC; i++) begin
      if (lo_r[i]) begin
        hi_ext_s = hi_ext_s + ({{BPC{1'b0}}, a_r} << i);
      end else begin
        hi_ext_s = hi_ext_s;
      end
    end
    mul_hi_s = hi_ext_s[WIDTH+BPC-1:BPC];
    mul_lo_s = {hi_ext_s[BPC-1:0], lo_r[WIDTH-1:BPC]};
    prod_s   = neg_r ? -{mul_hi_s, mul_lo_s} : {mul_hi_s, mul_lo_s};
  end

  // Select next datapath state and the signed result produced by the final iteration.
  always_comb begin
    step_hi_s = mul_hi_s;
    step_lo_s = mul_lo_s;
    final_s   = {WIDTH{1'b0}};
    case (fun_r)
      3'd0:             final_s = prod_s[WIDTH-1:0];
      3'd1, 3'd2, 3'd3: final_s = prod_s[2*WIDTH-1:WIDTH];
`ifdef URV_DIVIDE_EN
      3'd4, 3'd5: begin
        step_hi_s = div_r_s;
        step_lo_s = div_q_s;
        final_s   = neg_r ? -div_q_s : div_q_s;
      end
      3'd6, 3'd7: begin
        step_hi_s = div_r_s;
        step_lo_s = div_q_s;
        final_s   = neg_r ? -div_r_s : div_r_s;
      end
`endif
      default:          final_s = {WIDTH{1'b0}};
    endcase
  end

  // Control FSM and datapath registers; kill from any state discards the operation.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= S_IDLE;
      fun_r   <= 3'd0;
      a_r     <= {WIDTH{1'b0}};
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      rd_r    <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      neg_r   <= 1'b0;
    end else if (x_kill_i) begin
      state_r <= S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start_s) begin
            fun_r <= d_fun_i;
            a_r   <= d_fun_i[2] ? mag2_s : mag1_s;
            lo_r  <= d_fun_i[2] ? mag1_s : mag2_s;
            hi_r  <= {WIDTH{1'b0}};
            cnt_r <= {CW{1'b0}};
            neg_r <= neg_s;
            if (fast_s) begin
              rd_r    <= fast_res_s;
              state_r <= S_DONE;
            end else begin
              state_r <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          hi_r  <= step_hi_s;
          lo_r  <= step_lo_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == LAST_ITER) begin
            rd_r    <= final_s;
            state_r <= S_DONE;
          end
        end
        S_DONE: begin
          if (!x_stall_i) begin
            state_r <= S_IDLE;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/urv_muldiv_seq.md
URV_MULDIV_SEQ -- requirements
Module: urv_muldiv_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width; legal values 16, 32, 64.
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 1: bits retired per iteration; legal values 1, 2, 4; must divide WIDTH.
REQ-003 SHALL have port clk_i  in  1  clock; reset rst_i, asynchronous, active-low.
REQ-004 SHALL have port rst_i  in  1  asynchronous active-low reset.
REQ-005 SHALL have port x_stall_i  in  1  pipeline stall from the core; high means the exec stage holds.
REQ-006 SHALL have port x_kill_i  in  1  flush current exec instruction.
REQ-007 SHALL have port d_valid_i  in  1  decode outputs valid.
REQ-008 SHALL have port d_is_muldiv_i  in  1  instruction is an M-extension op.
REQ-009 SHALL have port d_fun_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-010 SHALL have ports d_rs1_i and d_rs2_i  in  WIDTH  operands.
REQ-011 SHALL have port x_stall_req_o  out  1  stall request to pipeline control.
REQ-012 SHALL have port x_rd_o  out  WIDTH  result.
REQ-013 SHALL have port x_done_o  out  1  result valid.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE; N = WIDTH/BITS_PER_CYCLE.
REQ-015 SHALL define start = IDLE & d_valid_i & d_is_muldiv_i & !x_kill_i.
REQ-016 SHALL capture rs1, rs2 and fun on start; later input changes are ignored until IDLE.
REQ-017 SHALL drive x_stall_req_o combinationally high on start and in BUSY, and low in IDLE (without start) and in DONE.
REQ-018 SHALL move IDLE->BUSY on start, run exactly N iterations in BUSY, then enter DONE; total stall = N+1 cycles (33 for 32/1, 17 for 32/2).
REQ-019 SHALL iterate in BUSY regardless of x_stall_i.
REQ-020 SHALL assert x_done_o and hold x_rd_o stable in DONE; DONE->IDLE on the first cycle with !x_stall_i, while DONE holds with x_stall_i high.
REQ-021 SHALL take a new start no earlier than the cycle after leaving DONE.
REQ-022 SHALL return MUL as the low WIDTH bits of the product, and MULH/MULHSU/MULHU as the high WIDTH bits with signed×signed, signed×unsigned and unsigned×unsigned interpretation.
REQ-023 SHALL produce quotients rounded toward zero for DIV/DIVU, with the REM sign equal to the dividend sign.
REQ-024 SHALL, for divide by zero, return a quotient of all ones and a remainder equal to rs1, going IDLE->DONE directly with a 1-cycle stall.
REQ-025 SHALL, for signed overflow (rs1 = most negative, rs2 = -1), return a quotient equal to rs1 and a remainder of 0, going IDLE->DONE directly.
REQ-026 SHALL, on x_kill_i in any state, go to IDLE next cycle with x_done_o=0 and x_stall_req_o=0 from that cycle, discarding the operation.
REQ-027 SHALL never start when x_kill_i and a start condition coincide.

Reset
REQ-028 SHALL, on rst_i low, force state IDLE, x_done_o=0, x_rd_o=0 and all operand, accumulator and counter registers to 0.
REQ-029 SHALL, if reset is asserted mid-operation, abort the operation with no residual effect after release.

Configuration
REQ-030 SHALL, with URV_DIVIDE_EN defined, support fun 4-7 as specified.
REQ-031 SHALL, with URV_DIVIDE_EN undefined, omit the divider datapath; fun 4-7 go IDLE->DONE with x_rd_o=0 and a 1-cycle stall, and multiply behaviour is unchanged.

Verification (WIDTH=32, BITS_PER_CYCLE=1 unless stated)
REQ-032 SHALL test MUL 7 × 0xFFFFFFFD -> 0xFFFFFFEB with x_stall_req_o high for exactly 33 cycles; with BITS_PER_CYCLE=2, 17 cycles.
REQ-033 SHALL test MULH 0x80000000 × 0x80000000 -> 0x40000000, MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE and MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
REQ-034 SHALL test DIV 0xFFFFFFEC / 3 -> 0xFFFFFFFA and REM -> 0xFFFFFFFE.
REQ-035 SHALL test DIVU 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5, each with a 1-cycle stall; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0.
REQ-036 SHALL test x_kill_i on BUSY cycle 10 -> next cycle IDLE with stall and done both 0, followed by MUL 3 × 4 -> 12 correct.
REQ-037 SHALL test x_stall_i held high 5 cycles in DONE -> x_rd_o stable, x_done_o high, leaving DONE on the first cycle with x_stall_i low.
